// File: rtl/lcd_frame_sched.sv
// lcd_frame_sched: triple-buffer frame scheduler for the LCD frame store.
// Writes PPU pixels into one of three banks and publishes only complete HxV frames.
// At each scan-out frame start it hands the newest published bank to scan-out.
//
// Build option: LCD_SKIP_FIRST_FRAME_EN discards the first frame after `on` rises.
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   clkena         PPU pixel-valid strobe (one pixel per asserted cycle)
//   mode           PPU mode, 2'd1 = vblank
//   on             LCD enable
//   rd_frame_start scan-out start-of-frame pulse (already in clk domain)
//   wr_en/wr_addr  registered frame-store write, wr_addr = {bank, offset[14:0]}
//   rd_bank        bank scan-out reads
//   rd_valid       rd_bank holds a published frame
//   frame_pub      one-cycle pulse: frame published
//   frame_drop     one-cycle pulse: short/overflowed frame discarded
module lcd_frame_sched #(
  parameter int unsigned H = 160,
  parameter int unsigned V = 144
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkena,
  input  logic [1:0]  mode,
  input  logic        on,
  input  logic        rd_frame_start,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [1:0]  rd_bank,
  output logic        rd_valid,
  output logic        frame_pub,
  output logic        frame_drop
);

  localparam logic [14:0] FS = 15'(H * V);

`ifdef LCD_SKIP_FIRST_FRAME_EN
  typedef enum logic [1:0] {ST_OFF, ST_SKIP, ST_DRAW, ST_VBL} state_t;
`else
  typedef enum logic [1:0] {ST_OFF, ST_DRAW, ST_VBL} state_t;
`endif

  state_t      state, state_n;
  logic [1:0]  w_bank, r_bank, d_bank;
  logic [1:0]  w_n, r_n, d_n;
  logic [14:0] cnt, cnt_n;
  logic        ovf, ovf_n;
  logic        fresh, fresh_n;
  logic        valid_n;
  logic [1:0]  prev_mode;
  logic        wr_en_n, pub_n, drop_n;
  logic [16:0] wr_addr_n;
  logic        vbl_entry;

  assign vbl_entry = (mode == 2'd1) && (prev_mode != 2'd1);
  assign rd_bank   = d_bank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OFF;
      w_bank     <= 2'd0;
      r_bank     <= 2'd1;
      d_bank     <= 2'd2;
      cnt        <= '0;
      ovf        <= 1'b0;
      fresh      <= 1'b0;
      rd_valid   <= 1'b0;
      prev_mode  <= 2'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      frame_pub  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_n;
      w_bank     <= w_n;
      r_bank     <= r_n;
      d_bank     <= d_n;
      cnt        <= cnt_n;
      ovf        <= ovf_n;
      fresh      <= fresh_n;
      rd_valid   <= valid_n;
      prev_mode  <= mode;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      frame_pub  <= pub_n;
      frame_drop <= drop_n;
    end
  end

  always_comb begin
    state_n   = state;
    w_n       = w_bank;
    r_n       = r_bank;
    d_n       = d_bank;
    cnt_n     = cnt;
    ovf_n     = ovf;
    fresh_n   = fresh;
    valid_n   = rd_valid;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    pub_n     = 1'b0;
    drop_n    = 1'b0;

    if (!on) begin
      // Partial frame is silently abandoned; bank indices survive.
      state_n = ST_OFF;
      cnt_n   = '0;
      ovf_n   = 1'b0;
      fresh_n = 1'b0;
      valid_n = 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
`ifdef LCD_SKIP_FIRST_FRAME_EN
          state_n = ST_SKIP;
`else
          state_n = ST_DRAW;
`endif
          cnt_n = '0;
          ovf_n = 1'b0;
        end
`ifdef LCD_SKIP_FIRST_FRAME_EN
        ST_SKIP: begin
          if (vbl_entry) state_n = ST_VBL;
        end
`endif
        ST_DRAW: begin
          if (clkena) begin
            if (cnt < FS) begin
              wr_en_n   = 1'b1;
              wr_addr_n = {w_bank, cnt};
              cnt_n     = cnt + 15'd1;
            end else begin
              ovf_n = 1'b1;
            end
          end
          // Evaluate on the post-pixel count so a pixel landing on the
          // vblank-entry cycle still completes the frame.
          if (vbl_entry) begin
            state_n = ST_VBL;
            if (cnt_n == FS && !ovf_n) begin
              r_n     = w_bank;
              w_n     = r_bank;
              fresh_n = 1'b1;
              pub_n   = 1'b1;
            end else begin
              drop_n = 1'b1;
            end
          end
        end
        ST_VBL: begin
          if (mode != 2'd1) begin
            state_n = ST_DRAW;
            cnt_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: state_n = ST_OFF;
      endcase

      // Swap works on the post-publish indices so a same-cycle publish
      // goes straight to display.
      if (rd_frame_start && state != ST_OFF && fresh_n) begin
        d_n     = r_n;
        r_n     = d_bank;
        fresh_n = 1'b0;
        valid_n = 1'b1;
      end
    end
  end

endmodule
